mux_rr_selector: RTL



---
 rtl/mux_rr_selector_pkg.sv | 6 +
 rtl/mux_rr_selector_picker.sv | 26 ++
 rtl/mux_rr_selector.sv | 86 ++++++++
 3 files changed

// File: rtl/mux_rr_selector_pkg.sv
// mux_rr_selector_pkg: shared state type and limits for the round-robin mux select sequencer.
package mux_rr_selector_pkg;
    typedef enum logic {IDLE, GRANT} state_e;
    localparam int MAX_CHANNELS = 16;
    localparam int MAX_DWELL    = 255;
endpackage

// File: rtl/mux_rr_selector_picker.sv
// rr_priority_picker: combinational wrap-around search for the first requester after last_ptr.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] last_ptr_i,
    output logic          found_o,
    output logic [SW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);
    int j;
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last_ptr_i) + k) % N;
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = SW'(j);
            end
        end
        onehot_o = found_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/mux_rr_selector.sv
// mux_rr_selector: round-robin Enable/Select sequencer for an N:1 mux with a per-grant beat dwell.
// Optional MUX_RR_SELECTOR_CH0_PRIORITY_EN makes channel 0 win every arbitration it is eligible for.
module mux_rr_selector
    import mux_rr_selector_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DWELL_BEATS  = 1,
    localparam int SEL_WIDTH   = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    Clock_In,
    input  logic                    Reset_In,
    input  logic [NUM_CHANNELS-1:0] Request_In,
    input  logic                    Ready_In,
    output logic                    Enable_Out,
    output logic [SEL_WIDTH-1:0]    Select_Out,
    output logic [NUM_CHANNELS-1:0] Grant_Out,
    output logic                    Valid_Out,
    output logic [7:0]              Beat_Count_Out
);
    localparam int DWELL = DWELL_BEATS > MAX_DWELL ? MAX_DWELL : DWELL_BEATS;

    state_e                  state_q;
    logic [SEL_WIDTH-1:0]    sel_q, last_q, pk_idx, win_idx;
    logic [NUM_CHANNELS-1:0] grant_q, pk_req, pk_hot, win_hot;
    logic [7:0]              cnt_q;
    logic                    pk_found, win_found, upd_last, beat, rel, arb;

    assign Valid_Out = (state_q == GRANT) && Request_In[sel_q];
    assign beat      = Valid_Out && Ready_In;
    assign rel       = (state_q == GRANT) && ((beat && cnt_q == 8'(DWELL - 1)) || !Request_In[sel_q]);
    assign arb       = (state_q == IDLE) || rel;

`ifdef MUX_RR_SELECTOR_CH0_PRIORITY_EN
    logic ch0_held, take0;
    // A finishing channel-0 grant hands over to the rotation so others are not starved.
    assign ch0_held  = (state_q == GRANT) && (sel_q == '0);
    assign pk_req    = ch0_held ? (Request_In & ~NUM_CHANNELS'(1)) : Request_In;
    assign take0     = (Request_In[0] && !ch0_held) || !pk_found;
    assign win_found = pk_found || Request_In[0];
    assign win_idx   = take0 ? '0 : pk_idx;
    assign win_hot   = take0 ? NUM_CHANNELS'(1) : pk_hot;
    assign upd_last  = !take0;
`else
    assign pk_req    = Request_In;
    assign win_found = pk_found;
    assign win_idx   = pk_idx;
    assign win_hot   = pk_hot;
    assign upd_last  = 1'b1;
`endif

    rr_priority_picker #(.N(NUM_CHANNELS), .SW(SEL_WIDTH)) u_picker (
        .req_i      (pk_req),
        .last_ptr_i (last_q),
        .found_o    (pk_found),
        .idx_o      (pk_idx),
        .onehot_o   (pk_hot)
    );

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            last_q  <= SEL_WIDTH'(NUM_CHANNELS - 1);
        end else if (arb) begin
            cnt_q <= '0;
            if (win_found) begin
                state_q <= GRANT;
                sel_q   <= win_idx;
                grant_q <= win_hot;
                if (upd_last) last_q <= win_idx;
            end else begin
                state_q <= IDLE;
                grant_q <= '0;
            end
        end else if (beat) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign Enable_Out     = (state_q == GRANT);
    assign Select_Out     = sel_q;
    assign Grant_Out      = grant_q;
    assign Beat_Count_Out = cnt_q;
endmodule
